mmio_slot_bridge: RTL and testbench

MMIO_SLOT_BRIDGE -- requirements
Module: mmio_slot_bridge

---
 rtl/mmio_slot_bridge.sv | 77 +++++++
 tb/tb_mmio_slot_bridge.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_slot_bridge.sv
// mmio_slot_bridge: bridges a held-request CPU MMIO port onto 64 shared-bus register slots.
// Ports: clk, reset (async, active high); CPU side io_req/io_we/io_addr/io_wdata in,
// io_rdata/io_ack/io_err out; slot side slot_cs/slot_read/slot_write/slot_addr/slot_wr_data
// out, slot_rd_data (packed per-slot read data) in.
module mmio_slot_bridge #(
   parameter logic [63:0] SLOT_MASK = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_req,
   input  logic              io_we,
   input  logic [10:0]       io_addr,
   input  logic [31:0]       io_wdata,
   output logic [31:0]       io_rdata,
   output logic              io_ack,
   output logic              io_err,
   output logic [63:0]       slot_cs,
   output logic              slot_read,
   output logic              slot_write,
   output logic [4:0]        slot_addr,
   output logic [31:0]       slot_wr_data,
   input  logic [63:0][31:0] slot_rd_data
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t      state, state_nxt;
   logic [10:0] addr_q;
   logic        we_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic [5:0]  slot;
   logic        hit;
   assign slot         = addr_q[10:5];
   assign hit          = SLOT_MASK[slot];
   assign slot_addr    = addr_q[4:0];
   assign slot_wr_data = wdata_q;
   assign io_err       = err_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   // Strobes depend only on the state register and latched request, never on io_* directly.
   always_comb begin
      state_nxt  = state;
      slot_cs    = '0;
      slot_read  = 1'b0;
      slot_write = 1'b0;
      io_ack     = 1'b0;
      case (state)
         IDLE:   state_nxt = io_req ? ACCESS : IDLE;
         ACCESS: begin
            state_nxt  = RESP;
            slot_cs    = hit ? (64'd1 << slot) : '0;
            slot_read  = hit & ~we_q;
            slot_write = hit & we_q;
         end
         RESP: begin
            state_nxt = IDLE;
            io_ack    = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         io_rdata <= '0;
         err_q    <= 1'b0;
      end else if (state == IDLE && io_req) begin
         addr_q  <= io_addr;
         we_q    <= io_we;
         wdata_q <= io_wdata;
      end else if (state == ACCESS) begin
         io_rdata <= (hit && !we_q) ? slot_rd_data[slot] : '0;
         err_q    <= ~hit;
      end
endmodule

// File: tb/tb_mmio_slot_bridge.sv
// tb_mmio_slot_bridge: directed self-checking bench for mmio_slot_bridge (full and sparse slot masks).
module tb_mmio_slot_bridge;
   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              io_req = 1'b0;
   logic              io_we = 1'b0;
   logic [10:0]       io_addr = '0;
   logic [31:0]       io_wdata = '0;
   logic [63:0][31:0] rd;
   logic [31:0]       io_rdata, rdata_m;
   logic              io_ack, ack_m, io_err, err_m;
   logic [63:0]       slot_cs, cs_m;
   logic              slot_read, read_m, slot_write, write_m;
   logic [4:0]        slot_addr, addr_m;
   logic [31:0]       slot_wr_data, wd_m;
   int                n_tests = 0;
   int                n_fail = 0;

   always #5 clk = ~clk;

   mmio_slot_bridge dut (
      .clk(clk), .reset(reset), .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack), .io_err(io_err),
      .slot_cs(slot_cs), .slot_read(slot_read), .slot_write(slot_write),
      .slot_addr(slot_addr), .slot_wr_data(slot_wr_data), .slot_rd_data(rd)
   );

   mmio_slot_bridge #(.SLOT_MASK(64'h0F)) dut_m (
      .clk(clk), .reset(reset), .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(rdata_m), .io_ack(ack_m), .io_err(err_m),
      .slot_cs(cs_m), .slot_read(read_m), .slot_write(write_m),
      .slot_addr(addr_m), .slot_wr_data(wd_m), .slot_rd_data(rd)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic we, input logic [5:0] s, input logic [4:0] r, input logic [31:0] d);
      io_req   = 1'b1;
      io_we    = we;
      io_addr  = {s, r};
      io_wdata = d;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rd[i] = 32'hA000_0000 | i;
      rd[2] = 32'h1234_5678;
      tick();
      chk("rst_ack", io_ack, 0);
      chk("rst_err", io_err, 0);
      chk("rst_rdata", io_rdata, 0);
      chk("rst_cs", slot_cs, 0);
      chk("rst_rw", {slot_read, slot_write}, 0);
      chk("rst_addr", {slot_addr, slot_wr_data}, 0);
      reset = 1'b0;
      tick();
      chk("idle_ack", io_ack, 0);

      // read slot 2 reg 0
      start(1'b0, 6'd2, 5'd0, 32'h0);
      tick();
      io_req = 1'b0;
      chk("rd2_cs", slot_cs, 64'h4);
      chk("rd2_rw", {slot_read, slot_write}, 2'b10);
      chk("rd2_addr", slot_addr, 0);
      chk("rd2_noack", io_ack, 0);
      tick();
      chk("rd2_ack", io_ack, 1);
      chk("rd2_rdata", io_rdata, 32'h1234_5678);
      chk("rd2_err", io_err, 0);
      chk("rd2_cs_off", slot_cs, 0);
      chk("rd2_rd_off", slot_read, 0);
      tick();
      chk("rd2_ack_off", io_ack, 0);

      // write 3 to slot 5 reg 2
      start(1'b1, 6'd5, 5'd2, 32'h3);
      tick();
      io_req = 1'b0;
      chk("wr5_cs", slot_cs, 64'h20);
      chk("wr5_rw", {slot_read, slot_write}, 2'b01);
      chk("wr5_addr", slot_addr, 2);
      chk("wr5_wdata", slot_wr_data, 3);
      tick();
      chk("wr5_wr_off", slot_write, 0);
      chk("wr5_cs_off", slot_cs, 0);
      chk("wr5_ack", io_ack, 1);
      chk("wr5_rdata", io_rdata, 0);
      tick();
      chk("wr5_ack_off", io_ack, 0);

      // read slot 9: unpopulated in dut_m, populated in dut
      start(1'b0, 6'd9, 5'd0, 32'h0);
      tick();
      io_req = 1'b0;
      chk("m9_cs", cs_m, 0);
      chk("m9_rw", {read_m, write_m}, 0);
      chk("f9_cs", slot_cs, 64'h200);
      tick();
      chk("m9_cs2", cs_m, 0);
      chk("m9_ack", ack_m, 1);
      chk("m9_err", err_m, 1);
      chk("m9_rdata", rdata_m, 0);
      chk("f9_err", io_err, 0);
      chk("f9_rdata", io_rdata, 32'hA000_0009);
      tick();

      // back-to-back reads, io_req held high throughout
      start(1'b0, 6'd0, 5'd1, 32'h0);
      tick();
      io_addr = {6'd1, 5'd1};
      chk("b0_cs", slot_cs, 64'h1);
      tick();
      chk("b0_ack", io_ack, 1);
      chk("b0_rdata", io_rdata, 32'hA000_0000);
      tick();
      chk("b0_idle", {io_ack, slot_read}, 0);
      tick();
      io_addr = {6'd63, 5'd1};
      chk("b1_cs", slot_cs, 64'h2);
      tick();
      chk("b1_ack", io_ack, 1);
      chk("b1_rdata", io_rdata, 32'hA000_0001);
      tick();
      chk("b1_idle", {io_ack, slot_read}, 0);
      tick();
      io_req = 1'b0;
      chk("b63_cs", slot_cs, 64'h8000_0000_0000_0000);
      tick();
      chk("b63_ack", io_ack, 1);
      chk("b63_rdata", io_rdata, 32'hA000_003F);
      tick();

      // reset pulsed during the ACCESS cycle of a write
      start(1'b1, 6'd4, 5'd7, 32'hDEAD_BEEF);
      tick();
      chk("ra_wr", slot_write, 1);
      #2 reset = 1'b1;
      #1;
      chk("ra_wr_drop", slot_write, 0);
      chk("ra_cs_drop", slot_cs, 0);
      chk("ra_rdata", io_rdata, 0);
      chk("ra_misc", {io_ack, io_err, slot_read, slot_addr, slot_wr_data}, 0);
      tick();
      chk("ra_noack", io_ack, 0);
      start(1'b0, 6'd6, 5'd0, 32'h0);
      reset = 1'b0;
      tick();
      io_req = 1'b0;
      chk("ra_next_cs", slot_cs, 64'h40);
      chk("ra_next_ack0", io_ack, 0);
      tick();
      chk("ra_next_ack", io_ack, 1);
      chk("ra_next_rdata", io_rdata, 32'hA000_0006);
      tick();

      // address change during ACCESS must be ignored
      start(1'b0, 6'd3, 5'd4, 32'h0);
      tick();
      io_addr = {6'd7, 5'd9};
      io_req  = 1'b0;
      #1;
      chk("ig_cs", slot_cs, 64'h8);
      chk("ig_addr", slot_addr, 4);
      tick();
      chk("ig_ack", io_ack, 1);
      chk("ig_rdata", io_rdata, 32'hA000_0003);
      tick();
      chk("ig_done", {io_ack, slot_cs}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
